// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: IDLE/RUN/DONE handshake, branch/step PC, saturating run counters.
// Latency: every input acts at the next rising edge; all outputs come straight from flops.
// Backpressure: stall freezes pc, taken_cnt and state; only cycle_cnt advances.
module pc_sequencer #(
    parameter int PC_W  = 8,
    parameter int CYC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             branch_en,
    input  logic             branch_cond,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             halt,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             done,
    output logic [7:0]       taken_cnt,
    output logic [CYC_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             taken;
    logic [PC_W-1:0]  pc_nxt;
    logic [7:0]       taken_nxt;
    logic [CYC_W-1:0] cycle_nxt;
    logic [7:0]       taken_inc;
    logic [CYC_W-1:0] cycle_inc;

    assign taken = branch_en & branch_cond;

    // Saturating increments: hold at all-ones rather than wrap.
    assign taken_inc = (taken_cnt == 8'hFF) ? taken_cnt : taken_cnt + 8'd1;
    assign cycle_inc = (cycle_cnt == {CYC_W{1'b1}}) ? cycle_cnt : cycle_cnt + CYC_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!stall && halt) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        running = 1'b0;
        done    = 1'b0;
        unique case (state)
            RUN:     running = 1'b1;
            DONE:    done    = 1'b1;
            default: begin
                running = 1'b0;
                done    = 1'b0;
            end
        endcase
    end

    always_comb begin
        pc_nxt    = pc;
        taken_nxt = taken_cnt;
        cycle_nxt = cycle_cnt;
        unique case (state)
            IDLE, DONE: begin
                // Restart from DONE is the same transition as from IDLE.
                if (start) begin
                    pc_nxt    = '0;
                    taken_nxt = '0;
                    cycle_nxt = '0;
                end
            end
            RUN: begin
                cycle_nxt = cycle_inc;
                if (stall || halt) begin
                    pc_nxt = pc;
                end else if (taken) begin
                    pc_nxt    = branch_target;
                    taken_nxt = taken_inc;
                end else begin
                    pc_nxt = pc + PC_W'(1);
                end
            end
            default: begin
                pc_nxt    = '0;
                taken_nxt = '0;
                cycle_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= '0;
            taken_cnt <= '0;
            cycle_cnt <= '0;
        end else begin
            pc        <= pc_nxt;
            taken_cnt <= taken_nxt;
            cycle_cnt <= cycle_nxt;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expectations queued by stimulus, popped by a monitor.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stall;
    logic        branch_en;
    logic        branch_cond;
    logic [7:0]  branch_target;
    logic        halt;
    logic [7:0]  pc;
    logic        running;
    logic        done;
    logic [7:0]  taken_cnt;
    logic [15:0] cycle_cnt;

    typedef struct {
        string       name;
        logic [7:0]  pc;
        logic        running;
        logic        done;
        logic [7:0]  taken;
        logic [15:0] cyc;
    } exp_t;

    exp_t q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    event sample_ev;

    pc_sequencer #(.PC_W(8), .CYC_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_cond   (branch_cond),
        .branch_target (branch_target),
        .halt          (halt),
        .pc            (pc),
        .running       (running),
        .done          (done),
        .taken_cnt     (taken_cnt),
        .cycle_cnt     (cycle_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ->sample_ev;
        end
    end

    // Monitor: every sample point that has a pending expectation gets compared.
    initial begin
        exp_t        e;
        logic [33:0] act;
        logic [33:0] req;
        forever begin
            @(sample_ev);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {pc, running, done, taken_cnt, cycle_cnt};
                req = {e.pc, e.running, e.done, e.taken, e.cyc};
                chk_cnt++;
                if (act === req) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL %s: got pc=%h run=%b done=%b taken=%h cyc=%h, want pc=%h run=%b done=%b taken=%h cyc=%h",
                             e.name, pc, running, done, taken_cnt, cycle_cnt,
                             e.pc, e.running, e.done, e.taken, e.cyc);
                end
            end
        end
    end

    task automatic push_exp(input string nm, input logic [7:0] epc, input logic er, input logic ed,
                            input logic [7:0] etk, input logic [15:0] ecy);
        exp_t e;
        e.name    = nm;
        e.pc      = epc;
        e.running = er;
        e.done    = ed;
        e.taken   = etk;
        e.cyc     = ecy;
        q.push_back(e);
    endtask

    // One clock: drive inputs at negedge, queue the state expected after the next posedge.
    task automatic cyc(input string nm, input logic st, input logic sl, input logic be, input logic bc,
                       input logic [7:0] tg, input logic hl,
                       input logic [7:0] epc, input logic er, input logic ed,
                       input logic [7:0] etk, input logic [15:0] ecy);
        @(negedge clk);
        start         = st;
        stall         = sl;
        branch_en     = be;
        branch_cond   = bc;
        branch_target = tg;
        halt          = hl;
        push_exp(nm, epc, er, ed, etk, ecy);
        @(posedge clk);
    endtask

    task automatic run(input string nm, input logic sl, input logic be, input logic bc,
                       input logic [7:0] tg, input logic hl,
                       input logic [7:0] epc, input logic [7:0] etk, input logic [15:0] ecy);
        cyc(nm, 1'b0, sl, be, bc, tg, hl, epc, 1'b1, 1'b0, etk, ecy);
    endtask

    task automatic async_check(input string nm);
        push_exp(nm, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0);
        ->sample_ev;
    endtask

    initial begin
        reset         = 1'b0;
        start         = 1'b0;
        stall         = 1'b0;
        branch_en     = 1'b0;
        branch_cond   = 1'b0;
        branch_target = 8'h00;
        halt          = 1'b0;
        #2;
        async_check("reset_init");
        cyc("reset_edge", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0);
        #2 reset = 1'b1;
        cyc("idle_nostart", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0);

        // First run: plain stepping, then halt at pc 7.
        cyc("start", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'd0);
        for (int i = 1; i <= 7; i++) begin
            run("plain_step", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'(i), 8'h00, 16'(i));
        end
        cyc("halt", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h07, 1'b0, 1'b1, 8'h00, 16'd8);
        cyc("done_hold", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h07, 1'b0, 1'b1, 8'h00, 16'd8);
        cyc("done_ign_br", 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 8'h07, 1'b0, 1'b1, 8'h00, 16'd8);

        // Restart from DONE, branches and stall priority.
        cyc("restart", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'd0);
        for (int i = 1; i <= 3; i++) begin
            run("plain_step2", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'(i), 8'h00, 16'(i));
        end
        run("br_taken", 1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 8'h40, 8'h01, 16'd4);
        run("br_back", 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 8'h03, 8'h02, 16'd5);
        run("br_not_taken", 1'b0, 1'b1, 1'b0, 8'h40, 1'b0, 8'h04, 8'h02, 16'd6);
        for (int i = 5; i <= 9; i++) begin
            run("plain_step3", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'(i), 8'h02, 16'(i + 2));
        end
        run("stall_prio", 1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 8'h09, 8'h02, 16'd12);
        cyc("start_in_run", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h0A, 1'b1, 1'b0, 8'h02, 16'd13);
        run("br_self1", 1'b0, 1'b1, 1'b1, 8'h0A, 1'b0, 8'h0A, 8'h03, 16'd14);
        run("br_self2", 1'b0, 1'b1, 1'b1, 8'h0A, 1'b0, 8'h0A, 8'h04, 16'd15);
        run("br_to_11", 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 8'h11, 8'h05, 16'd16);
        run("to_12", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h12, 8'h05, 16'd17);

        // Reset between edges while running at pc 0x12.
        #3 reset = 1'b0;
        #1 async_check("reset_midrun");
        cyc("reset_hold", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0);
        #2 reset = 1'b1;
        cyc("idle_after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0);

        // PC wrap and taken-count saturation.
        cyc("start3", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'd0);
        for (int i = 1; i <= 256; i++) begin
            run((i == 256) ? "pc_wrap" : "pc_walk", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0,
                8'(i), 8'h00, 16'(i));
        end
        for (int k = 1; k <= 300; k++) begin
            run("taken_sat", 1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 8'h20,
                8'((k > 255) ? 255 : k), 16'(256 + k));
        end
        cyc("halt3", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h20, 1'b0, 1'b1, 8'hFF, 16'd557);
        cyc("done_hold3", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h20, 1'b0, 1'b1, 8'hFF, 16'd557);

        repeat (2) @(posedge clk);
        #2;
        chk_cnt++;
        if (q.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
